gpi_debounce_bank: RTL and testbench
====================================

Name: gpi_debounce_bank

Overview:
- Parametrised input-conditioning bank for board switches/buttons feeding the demo system's GPI port.
- Generalises the fixed 4 SW + 4 BTN wiring: any channel count, with per-channel synchronisation, counter-based debounce and rise/fall edge pulses.
- Optional sticky edge-status interrupt.
- Sits between the board pins and the `gp_i` input of `ibex_demo_system`, inside the board top.

Parameters:
- NumIn, 8, number of input channels (1..32).
- SyncStages, 2, flip-flop synchroniser depth (>= 2).
- DebounceCycles, 50000, consecutive stable cycles required to accept a new level (>= 1).
- ResetValue, '0, NumIn-bit reset/initial level for every channel.

Ports:
- clk_sys_i  input  1  system clock
- rst_sys_ni  input  1  asynchronous active-low reset
- raw_i  input  NumIn  asynchronous board inputs (SW/BTN)
- level_o  output  NumIn  debounced level; drives gp_i
- rise_o  output  NumIn  one-cycle pulse on accepted 0->1
- fall_o  output  NumIn  one-cycle pulse on accepted 1->0
- irq_rise_en_i  input  NumIn  per-channel rise-capture enable
- irq_fall_en_i  input  NumIn  per-channel fall-capture enable
- status_clr_i  input  NumIn  write-1-to-clear pulse for status bits
- status_o  output  NumIn  sticky edge-captured bits
- irq_o  output  1  OR of status_o

Behaviour:
- One clock: clk_sys_i. Reset is asynchronous, active-low: rst_sys_ni.
- Reset values:
  - Synchroniser flops = ResetValue; level_o = ResetValue.
  - Debounce counters = 0; rise_o = fall_o = 0; status_o = 0; irq_o = 0.
- Synchroniser: raw_i passes through SyncStages flops per channel. Its output is sync[i].
- Debounce counter per channel, width $clog2(DebounceCycles+1):
  - sync[i] == level_o[i]: counter cleared to 0.
  - sync[i] != level_o[i] and counter < DebounceCycles-1: counter increments.
  - sync[i] != level_o[i] and counter == DebounceCycles-1: level_o[i] <= sync[i]; counter <= 0.
  - A glitch shorter than DebounceCycles synchronised cycles clears the counter and is never accepted.
- Latency: a clean raw_i step changes level_o exactly SyncStages + DebounceCycles rising edges after it is first sampled.
  - DebounceCycles = 1 gives latency SyncStages + 1.
- Edge pulses:
  - rise_o[i] / fall_o[i] are registered and high for exactly one cycle, the same cycle level_o[i] first shows its new value.
  - Never both high on the same channel in the same cycle.
- No spurious edges after reset: with raw_i == ResetValue at reset release, no pulse is emitted.
- Channels are fully independent; any number may change in the same cycle.
- Reset mid-count: counter discarded; level_o returns to ResetValue; no pulse emitted.

Optional Feature:
- Macro: GPI_DEBOUNCE_EDGE_IRQ_EN.
- Defined:
  - status_o[i] sets on (rise_o[i] & irq_rise_en_i[i]) | (fall_o[i] & irq_fall_en_i[i]).
  - status_o[i] clears on status_clr_i[i].
  - Set wins over a simultaneous clear.
  - irq_o = |status_o (combinational from the status register), so it is high one cycle after the edge pulse.
- Undefined: status_o and irq_o are tied 0; the enable and clear inputs are ignored; no status flops are present.

Test Plan:
- Reset release, NumIn=8, SyncStages=2, DebounceCycles=4, ResetValue=0, raw_i=0 -> level_o=0, no rise/fall pulse, irq_o=0 for 20 cycles.
- raw_i[0] steps 0->1 and holds -> level_o[0]=1 exactly 6 edges later; rise_o[0]=1 for one cycle in that same cycle; all other channels unchanged.
- raw_i[3] high for 3 cycles, then low -> level_o[3] stays 0; rise_o[3] is never asserted; counter back to 0.
- raw_i=8'hFF then 8'h00, each held 10 cycles -> rise_o=8'hFF in a single cycle, later fall_o=8'hFF in a single cycle; level_o tracks with 6-cycle latency.
- With GPI_DEBOUNCE_EDGE_IRQ_EN defined, irq_rise_en_i=8'h01, raw_i[0] 0->1 -> status_o=8'h01 and irq_o=1 the cycle after rise_o[0]. Then status_clr_i=8'h01 for one cycle -> status_o=0, irq_o=0. A clear coincident with a new set -> the bit stays 1.
- Drive rst_sys_ni low mid-count (counter=2) with raw_i[1]=1 -> level_o=0 asynchronously. After release, level_o[1]=1 at SyncStages+DebounceCycles edges; exactly one rise pulse.

Source files
------------

// File: rtl/gpi_debounce_bank.sv
// GPI input-conditioning bank: per-channel synchroniser, counter debounce, rise/fall pulses.
// Optional sticky edge-status interrupt enabled by defining GPI_DEBOUNCE_EDGE_IRQ_EN.

module gpi_debounce_lane #(
   parameter int unsigned SyncStages     = 2,
   parameter int unsigned DebounceCycles = 50000,
   parameter logic        ResetBit       = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);
   localparam int unsigned CW = $clog2(DebounceCycles + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DebounceCycles - 1);

   logic [SyncStages-1:0] r_sync;
   logic [CW-1:0]         r_cnt;
   logic                  r_level;
   logic                  r_rise;
   logic                  r_fall;
   logic                  w_sync;

   assign w_sync = r_sync[SyncStages-1];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= {SyncStages{ResetBit}};
      end else begin
         r_sync <= {r_sync[SyncStages-2:0], i_raw};
      end
   end

   // Level only moves after DebounceCycles consecutive disagreeing samples;
   // the edge pulse is registered alongside it so both appear in the same cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt   <= '0;
         r_level <= ResetBit;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         if (w_sync == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_cnt   <= '0;
            r_level <= w_sync;
            r_rise  <= w_sync;
            r_fall  <= ~w_sync;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;
endmodule

module gpi_debounce_bank #(
   parameter int unsigned            NumIn          = 8,
   parameter int unsigned            SyncStages     = 2,
   parameter int unsigned            DebounceCycles = 50000,
   parameter logic [NumIn-1:0]       ResetValue     = '0
) (
   input  logic             clk_sys_i,
   input  logic             rst_sys_ni,
   input  logic [NumIn-1:0] raw_i,
   output logic [NumIn-1:0] level_o,
   output logic [NumIn-1:0] rise_o,
   output logic [NumIn-1:0] fall_o,
   input  logic [NumIn-1:0] irq_rise_en_i,
   input  logic [NumIn-1:0] irq_fall_en_i,
   input  logic [NumIn-1:0] status_clr_i,
   output logic [NumIn-1:0] status_o,
   output logic             irq_o
);
   for (genvar g = 0; g < NumIn; g++) begin : g_lane
      gpi_debounce_lane #(
         .SyncStages     (SyncStages),
         .DebounceCycles (DebounceCycles),
         .ResetBit       (ResetValue[g])
      ) u_lane (
         .i_clk   (clk_sys_i),
         .i_rst_n (rst_sys_ni),
         .i_raw   (raw_i[g]),
         .o_level (level_o[g]),
         .o_rise  (rise_o[g]),
         .o_fall  (fall_o[g])
      );
   end

`ifdef GPI_DEBOUNCE_EDGE_IRQ_EN
   logic [NumIn-1:0] r_status;
   logic [NumIn-1:0] w_set;

   assign w_set = (rise_o & irq_rise_en_i) | (fall_o & irq_fall_en_i);

   // A new edge wins over a clear landing in the same cycle.
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         r_status <= '0;
      end else begin
         r_status <= (r_status & ~status_clr_i) | w_set;
      end
   end

   assign status_o = r_status;
   assign irq_o    = |r_status;
`else
   logic w_unused;
   assign w_unused = ^{irq_rise_en_i, irq_fall_en_i, status_clr_i};
   assign status_o = '0;
   assign irq_o    = 1'b0;
`endif
endmodule

// File: tb/tb_gpi_debounce_bank.sv
// Directed bench for gpi_debounce_bank: table-driven cycle vectors plus irq and reset sequences.
`timescale 1ns/1ps
module tb_gpi_debounce_bank;
`ifdef GPI_DEBOUNCE_EDGE_IRQ_EN
   localparam bit IRQ = 1'b1;
`else
   localparam bit IRQ = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] raw = '0, ren = '0, fen = '0, clr = '0;
   logic [7:0] level, rise, fall, status;
   logic       irq;
   int         checks = 0, failures = 0;

   always #5 clk = ~clk;

   gpi_debounce_bank #(
      .NumIn(8), .SyncStages(2), .DebounceCycles(4), .ResetValue(8'h00)
   ) dut (
      .clk_sys_i(clk), .rst_sys_ni(rst_n), .raw_i(raw),
      .level_o(level), .rise_o(rise), .fall_o(fall),
      .irq_rise_en_i(ren), .irq_fall_en_i(fen), .status_clr_i(clr),
      .status_o(status), .irq_o(irq)
   );

   typedef struct {
      logic [7:0] raw;
      logic [7:0] lvl;
      logic [7:0] rise;
      logic [7:0] fall;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input int n, input logic [7:0] r, l, ri, fa);
      vec_t v;
      v.raw = r; v.lvl = l; v.rise = ri; v.fall = fa;
      repeat (n) tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int nrise1;

   initial begin
      // idle after reset release with raw == ResetValue
      add(20, 8'h00, 8'h00, 8'h00, 8'h00);
      // clean step on ch0: accepted on the 6th edge
      add(5, 8'h01, 8'h00, 8'h00, 8'h00);
      add(1, 8'h01, 8'h01, 8'h01, 8'h00);
      add(2, 8'h01, 8'h01, 8'h00, 8'h00);
      // 3-cycle glitch on ch3 is rejected
      add(3, 8'h09, 8'h01, 8'h00, 8'h00);
      add(5, 8'h01, 8'h01, 8'h00, 8'h00);
      // 4-cycle pulse on ch3 is the shortest accepted one
      add(4, 8'h09, 8'h01, 8'h00, 8'h00);
      add(1, 8'h01, 8'h01, 8'h00, 8'h00);
      add(1, 8'h01, 8'h09, 8'h08, 8'h00);
      add(3, 8'h01, 8'h09, 8'h00, 8'h00);
      add(1, 8'h01, 8'h01, 8'h00, 8'h08);
      add(2, 8'h01, 8'h01, 8'h00, 8'h00);
      // ch0 back to 0
      add(5, 8'h00, 8'h01, 8'h00, 8'h00);
      add(1, 8'h00, 8'h00, 8'h00, 8'h01);
      add(4, 8'h00, 8'h00, 8'h00, 8'h00);
      // all channels together
      add(5, 8'hFF, 8'h00, 8'h00, 8'h00);
      add(1, 8'hFF, 8'hFF, 8'hFF, 8'h00);
      add(4, 8'hFF, 8'hFF, 8'h00, 8'h00);
      add(5, 8'h00, 8'hFF, 8'h00, 8'h00);
      add(1, 8'h00, 8'h00, 8'h00, 8'hFF);
      add(4, 8'h00, 8'h00, 8'h00, 8'h00);

      #2;
      chk("rst_level", level, 8'h00);
      chk("rst_rise", rise, 8'h00);
      chk("rst_fall", fall, 8'h00);
      chk("rst_status", status, 8'h00);
      chk("rst_irq", {7'd0, irq}, 8'h00);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      foreach (tbl[i]) begin
         raw = tbl[i].raw;
         step();
         chk($sformatf("v%0d_level", i), level, tbl[i].lvl);
         chk($sformatf("v%0d_rise", i), rise, tbl[i].rise);
         chk($sformatf("v%0d_fall", i), fall, tbl[i].fall);
         chk($sformatf("v%0d_both", i), rise & fall, 8'h00);
         chk($sformatf("v%0d_irq", i), {status[6:0], irq}, 8'h00);
      end

      // sticky status: set, clear, set-beats-clear
      ren = 8'h01;
      raw = 8'h01;
      repeat (5) step();
      chk("irq_pre_rise", rise, 8'h00);
      step();
      chk("irq_rise", rise, 8'h01);
      chk("irq_status_lag", status, 8'h00);
      step();
      chk("irq_status_set", status, IRQ ? 8'h01 : 8'h00);
      chk("irq_o_set", {7'd0, irq}, {7'd0, IRQ});
      clr = 8'h01;
      step();
      clr = 8'h00;
      chk("irq_status_clr", status, 8'h00);
      chk("irq_o_clr", {7'd0, irq}, 8'h00);
      fen = 8'h01;
      raw = 8'h00;
      repeat (6) step();
      chk("irq_fall", fall, 8'h01);
      clr = 8'h01;
      step();
      clr = 8'h00;
      chk("irq_set_wins", status, IRQ ? 8'h01 : 8'h00);
      chk("irq_o_set_wins", {7'd0, irq}, {7'd0, IRQ});
      clr = 8'h01;
      step();
      clr = 8'h00;
      ren = 8'h00;
      fen = 8'h00;
      chk("irq_final_clr", status, 8'h00);

      // reset mid-count: ch0 settled high, ch1 counter at 2
      raw = 8'h01;
      repeat (8) step();
      chk("mid_pre_level", level, 8'h01);
      raw = 8'h03;
      repeat (4) step();
      chk("mid_count_level", level, 8'h01);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_async_level", level, 8'h00);
      chk("mid_async_rise", rise, 8'h00);
      chk("mid_async_status", status, 8'h00);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      nrise1 = 0;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (rise[1]) nrise1++;
         chk($sformatf("post_rst%0d_fall", k), fall, 8'h00);
         if (k < 6) chk($sformatf("post_rst%0d_level", k), level, 8'h00);
         else       chk($sformatf("post_rst%0d_level", k), level, 8'h03);
         chk($sformatf("post_rst%0d_rise", k), rise, (k == 6) ? 8'h03 : 8'h00);
      end
      chk("post_rst_one_rise", 8'(nrise1), 8'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
